// File: rtl/edge_evt_pkg.sv
// Shared constants, FSM state type and width helper for the edge-event collector.
package edge_evt_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {PRIME, RUN} fsm_state_t;

  function automatic int unsigned cw_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Per-channel synchroniser, history flop and registered, mode/enable-qualified edge pulses.
module edge_sync_det
  import edge_evt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  EDGE_MODE   = EDGE_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_hist <= w_sync;
      r_rise <= i_en & EDGE_MODE[0] & w_sync & ~r_hist;
      r_fall <= i_en & EDGE_MODE[1] & ~w_sync & r_hist;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event collector: per-channel pending latches, round-robin
// arbitration and a one-deep valid/ready output slot.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  EDGE_MODE   = EDGE_RISE,
  localparam int unsigned CW         = cw_of(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] sig_in,
  input  logic [CH-1:0] ch_en,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_ch,
  output logic          evt_pol,
  output logic [CH-1:0] overflow,
  input  logic          ovf_clr
);

  localparam int unsigned CNTW = $clog2(SYNC_STAGES + 2);

  fsm_state_t      r_state, w_next;
  logic [CNTW-1:0] r_cnt;
  logic            w_run;

  logic [CH-1:0]   w_rise, w_fall, w_grant, w_ovf_set;
  logic [CH-1:0]   r_pend, r_pol, r_ovf;
  logic [CW-1:0]   r_ptr, w_win;
  logic            w_found, w_load, w_take;
  logic            r_evt_valid, r_evt_pol;
  logic [CW-1:0]   r_evt_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRIME;
      r_cnt   <= CNTW'(SYNC_STAGES);
    end else begin
      r_state <= w_next;
      if (r_state == PRIME && r_cnt != '0) r_cnt <= r_cnt - CNTW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == PRIME && r_cnt == '0) w_next = RUN;
  end

  always_comb begin
    w_run = (r_state == RUN);
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_sync_det #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (sig_in[g]),
      .i_en   (ch_en[g] & w_run),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  // Round-robin search starting at the pointer, wrapping CH-1 -> 0.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = 32'(r_ptr) + i;
      if (idx >= CH) idx = idx - CH;
      if (!w_found && r_pend[idx]) begin
        w_found = 1'b1;
        w_win   = CW'(idx);
      end
    end
  end

  assign w_load = !r_evt_valid || evt_ready;
  assign w_take = w_load && w_found;

  always_comb begin
    w_grant   = '0;
    w_ovf_set = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      w_grant[c]   = w_take && (32'(w_win) == c);
      w_ovf_set[c] = (w_rise[c] | w_fall[c]) & r_pend[c] & ~w_grant[c];
    end
  end

  // A grant and a new edge on the same cycle re-arm the pending bit with the new polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_pol  <= '0;
      r_ovf  <= '0;
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        if (w_rise[c] || w_fall[c]) begin
          if (w_grant[c] || !r_pend[c]) begin
            r_pend[c] <= 1'b1;
            r_pol[c]  <= w_rise[c];
          end
        end else if (w_grant[c]) begin
          r_pend[c] <= 1'b0;
        end
      end
      r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_pol   <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_evt_valid <= w_found;
      if (w_found) begin
        r_evt_ch  <= w_win;
        r_evt_pol <= r_pol[w_win];
        r_ptr     <= (w_win == CW'(CH - 1)) ? '0 : w_win + CW'(1);
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign evt_pol   = r_evt_pol;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench: one rising-only instance and one both-edges instance share all inputs.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sig_in = '0;
  logic [3:0] ch_en = '1;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;

  logic       evt_valid, evt_pol;
  logic [1:0] evt_ch;
  logic [3:0] overflow;
  logic       evt_valid2, evt_pol2;
  logic [1:0] evt_ch2;
  logic [3:0] overflow2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.CH(4), .SYNC_STAGES(2), .EDGE_MODE(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_pol(evt_pol), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  edge_event_arbiter #(.CH(4), .SYNC_STAGES(2), .EDGE_MODE(2'b11)) dut2 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en),
    .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_ch(evt_ch2),
    .evt_pol(evt_pol2), .overflow(overflow2), .ovf_clr(ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sig_in = '0; ch_en = '1; evt_ready = 1'b1;
    #2;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", evt_valid); end
    n_tests++; if (overflow !== 4'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0000", overflow); end
    n_tests++; if (evt_ch !== 2'd0 || evt_pol !== 1'b0) begin n_fail++; $display("FAIL rst_chpol got %0d/%b exp 0/0", evt_ch, evt_pol); end
    n_tests++; if (evt_valid2 !== 1'b0) begin n_fail++; $display("FAIL rst_valid2 got %b exp 0", evt_valid2); end
    do_reset();
  endtask

  task automatic test_single_rise();
    do_reset();
    evt_ready = 1'b1; ch_en = '1;
    sig_in = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++;
      if (evt_valid !== 1'(c == 5)) begin n_fail++; $display("FAIL t1_valid c=%0d got %b exp %b", c, evt_valid, 1'(c == 5)); end
      if (c == 5) begin
        n_tests++; if (evt_ch !== 2'd2) begin n_fail++; $display("FAIL t1_ch got %0d exp 2", evt_ch); end
        n_tests++; if (evt_pol !== 1'b1) begin n_fail++; $display("FAIL t1_pol got %b exp 1", evt_pol); end
      end
    end
    n_tests++; if (overflow !== 4'b0) begin n_fail++; $display("FAIL t1_ovf got %b exp 0000", overflow); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [3] = '{2'd0, 2'd1, 2'd3};
    logic [1:0] exp_b [2] = '{2'd1, 2'd3};
    do_reset();
    evt_ready = 1'b1;
    sig_in = 4'b1011;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_tests++;
      if (evt_valid !== 1'(c >= 5 && c <= 7)) begin n_fail++; $display("FAIL rr_a_valid c=%0d got %b", c, evt_valid); end
      if (c >= 5 && c <= 7) begin
        n_tests++; if (evt_ch !== exp_a[c-5]) begin n_fail++; $display("FAIL rr_a_ch c=%0d got %0d exp %0d", c, evt_ch, exp_a[c-5]); end
      end
    end
    sig_in = 4'b0000;
    repeat (4) tick();
    sig_in = 4'b1010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_tests++;
      if (evt_valid !== 1'(c >= 5 && c <= 6)) begin n_fail++; $display("FAIL rr_b_valid c=%0d got %b", c, evt_valid); end
      if (c >= 5 && c <= 6) begin
        n_tests++; if (evt_ch !== exp_b[c-5]) begin n_fail++; $display("FAIL rr_b_ch c=%0d got %0d exp %0d", c, evt_ch, exp_b[c-5]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int unstable = 0;
    do_reset();
    evt_ready = 1'b0;
    sig_in = 4'b0001;
    repeat (6) tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b1) begin n_fail++; $display("FAIL bp_first got v=%b ch=%0d pol=%b exp 1/0/1", evt_valid, evt_ch, evt_pol); end
    // rise #2 fills pending, rise #3 overflows
    for (int k = 0; k < 2; k++) begin
      sig_in = 4'b0000;
      repeat (2) begin tick(); if (!(evt_valid === 1'b1 && evt_ch === 2'd0 && evt_pol === 1'b1)) unstable++; end
      sig_in = 4'b0001;
      repeat (2) begin tick(); if (!(evt_valid === 1'b1 && evt_ch === 2'd0 && evt_pol === 1'b1)) unstable++; end
    end
    repeat (8) begin tick(); if (!(evt_valid === 1'b1 && evt_ch === 2'd0 && evt_pol === 1'b1)) unstable++; end
    n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable cycles exp 0", unstable); end
    n_tests++; if (overflow !== 4'b0001) begin n_fail++; $display("FAIL bp_ovf got %b exp 0001", overflow); end
    evt_ready = 1'b1;
    tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b1) begin n_fail++; $display("FAIL bp_second got v=%b ch=%0d pol=%b exp 1/0/1", evt_valid, evt_ch, evt_pol); end
    tick();
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", evt_valid); end
    n_tests++; if (overflow !== 4'b0001) begin n_fail++; $display("FAIL bp_ovf_sticky got %b exp 0001", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL bp_ovf_clr got %b exp 0000", overflow); end
  endtask

  task automatic test_high_at_reset();
    int n1 = 0;
    int n2 = 0;
    logic [1:0] ch2 = '0;
    logic pol2 = 1'b1;
    sig_in = 4'b1111; evt_ready = 1'b1;
    do_reset();
    repeat (20) begin tick(); if (evt_valid === 1'b1) n1++; if (evt_valid2 === 1'b1) n2++; end
    n_tests++; if (n1 !== 0) begin n_fail++; $display("FAIL hr_quiet got %0d events exp 0", n1); end
    n_tests++; if (n2 !== 0) begin n_fail++; $display("FAIL hr_quiet2 got %0d events exp 0", n2); end
    sig_in = 4'b1101;
    repeat (10) begin
      tick();
      if (evt_valid === 1'b1) n1++;
      if (evt_valid2 === 1'b1) begin n2++; ch2 = evt_ch2; pol2 = evt_pol2; end
    end
    n_tests++; if (n2 !== 1) begin n_fail++; $display("FAIL hr_fall_cnt got %0d exp 1", n2); end
    n_tests++; if (ch2 !== 2'd1 || pol2 !== 1'b0) begin n_fail++; $display("FAIL hr_fall_evt got ch=%0d pol=%b exp 1/0", ch2, pol2); end
    n_tests++; if (n1 !== 0) begin n_fail++; $display("FAIL hr_rise_only got %0d events exp 0", n1); end
  endtask

  task automatic test_both_edges();
    int cyc [2] = '{0, 0};
    logic [1:0] chs [2] = '{2'd0, 2'd0};
    logic pols [2] = '{1'b0, 1'b1};
    int n = 0;
    sig_in = 4'b0000; evt_ready = 1'b1;
    do_reset();
    sig_in = 4'b1000;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 3) sig_in = 4'b0000;
      if (evt_valid2 === 1'b1) begin
        if (n < 2) begin cyc[n] = c; chs[n] = evt_ch2; pols[n] = evt_pol2; end
        n++;
      end
    end
    n_tests++; if (n !== 2) begin n_fail++; $display("FAIL be_cnt got %0d exp 2", n); end
    n_tests++; if (chs[0] !== 2'd3 || pols[0] !== 1'b1) begin n_fail++; $display("FAIL be_rise got ch=%0d pol=%b exp 3/1", chs[0], pols[0]); end
    n_tests++; if (chs[1] !== 2'd3 || pols[1] !== 1'b0) begin n_fail++; $display("FAIL be_fall got ch=%0d pol=%b exp 3/0", chs[1], pols[1]); end
    n_tests++; if (cyc[0] !== 5 || cyc[1] !== 8) begin n_fail++; $display("FAIL be_timing got %0d,%0d exp 5,8", cyc[0], cyc[1]); end
    n_tests++; if (overflow2 !== 4'b0) begin n_fail++; $display("FAIL be_ovf got %b exp 0000", overflow2); end
  endtask

  task automatic test_enable_and_reset();
    int n = 0;
    sig_in = 4'b0000; evt_ready = 1'b1; ch_en = 4'b1011;
    do_reset();
    sig_in = 4'b0100;
    repeat (12) begin tick(); if (evt_valid === 1'b1 || evt_valid2 === 1'b1) n++; end
    n_tests++; if (n !== 0) begin n_fail++; $display("FAIL en_block got %0d events exp 0", n); end
    ch_en = 4'b1111; evt_ready = 1'b0;
    sig_in = 4'b0111;
    repeat (6) tick();
    n_tests++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin n_fail++; $display("FAIL mr_pre got v=%b ch=%0d exp 1/0", evt_valid, evt_ch); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mr_async got %b exp 0", evt_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    evt_ready = 1'b1;
    n = 0;
    repeat (15) begin tick(); if (evt_valid === 1'b1 || evt_valid2 === 1'b1) n++; end
    n_tests++; if (n !== 0) begin n_fail++; $display("FAIL mr_stale got %0d events exp 0", n); end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_round_robin();
    test_back_pressure();
    test_high_at_reset();
    test_both_edges();
    test_enable_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
